// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU / DMA memory arbiter and the CPU FSM integration.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CPU_OWN = 2'b01,
    DMA_OWN = 2'b10
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_hold_cnt.sv
// Saturating counter of consecutive owner accesses made while the other master waits.
module mem_arb_hold_cnt #(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  logic [3:0] count;

  assign expired = (count == 4'(MAX_HOLD - 1));

  // Clear has priority over increment; the count never passes MAX_HOLD-1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 4'd0;
    end else if (inc && !expired) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Two-master arbiter sharing the program/data memory between the CPU FSM and the DMA loader.
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wr_e,
  output logic              mem_re_e,
  output logic              mem_o_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state;
  arb_state_t next_state;
  logic       last_owner;
  logic       cpu_acc;
  logic       dma_acc;
  logic       other_req;
  logic       hold_inc;
  logic       hold_clr;
  logic       hold_expired;

  // Accesses are suppressed during reset so the memory sees no enables in that cycle.
  assign cpu_acc = cpu_req & cpu_gnt & ~rst;
  assign dma_acc = dma_req & dma_gnt & ~rst;

  // Request from whichever master is currently waiting on the owner.
  always_comb begin
    other_req = 1'b0;
    case (state)
      CPU_OWN: other_req = dma_req;
      DMA_OWN: other_req = cpu_req;
      default: other_req = 1'b0;
    endcase
  end

  assign hold_inc = (cpu_acc | dma_acc) & other_req;
  assign hold_clr = (next_state != state) | ~other_req;

  mem_arb_hold_cnt #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (hold_inc),
    .clr    (hold_clr),
    .expired(hold_expired)
  );

  // Ownership decision: round-robin on ties from idle, hand over on release or hold expiry.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cpu_req && dma_req) begin
          next_state = (last_owner == OWN_DMA) ? CPU_OWN : DMA_OWN;
        end else if (cpu_req) begin
          next_state = CPU_OWN;
        end else if (dma_req) begin
          next_state = DMA_OWN;
        end
      end
      CPU_OWN: begin
        if (!cpu_req) begin
          next_state = dma_req ? DMA_OWN : IDLE;
        end else if (dma_req && hold_expired) begin
          next_state = DMA_OWN;
        end
      end
      DMA_OWN: begin
        if (!dma_req) begin
          next_state = cpu_req ? CPU_OWN : IDLE;
        end else if (cpu_req && hold_expired) begin
          next_state = CPU_OWN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register with grants registered alongside it; remembers who owned last for round-robin.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_gnt    <= 1'b0;
      dma_gnt    <= 1'b0;
      last_owner <= OWN_DMA;
    end else begin
      state   <= next_state;
      cpu_gnt <= (next_state == CPU_OWN);
      dma_gnt <= (next_state == DMA_OWN);
      if (state != IDLE && next_state != state) begin
        last_owner <= (state == CPU_OWN) ? OWN_CPU : OWN_DMA;
      end
    end
  end

  // Read-return flags follow the requester, not the current owner, so they survive a handover.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_acc & ~cpu_we;
      dma_rvalid <= dma_acc & ~dma_we;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata = dma_rvalid ? mem_rdata : '0;

  // Memory pins carry only the owner's access; everything idles at zero otherwise.
  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    mem_wr_e    = 1'b0;
    mem_re_e    = 1'b0;
    mem_o_en    = 1'b0;
    if (cpu_acc) begin
      mem_address = cpu_addr;
      mem_wdata   = cpu_wdata;
      mem_wr_e    = cpu_we;
      mem_re_e    = ~cpu_we;
      mem_o_en    = ~cpu_we;
    end else if (dma_acc) begin
      mem_address = dma_addr;
      mem_wdata   = dma_wdata;
      mem_wr_e    = dma_we;
      mem_re_e    = ~dma_we;
      mem_o_en    = ~dma_we;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter with a byte memory model and read-data scoreboards.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_address;
  logic        mem_wr_e;
  logic        mem_re_e;
  logic        mem_o_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'hEE;

  logic [7:0]  mem [0:65535];
  logic [7:0]  cpuExp[$];
  logic [7:0]  dmaExp[$];
  int          testsRun = 0;
  int          testsFailed = 0;

  cpu_mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(8),
    .MAX_HOLD(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_address(mem_address),
    .mem_wr_e   (mem_wr_e),
    .mem_re_e   (mem_re_e),
    .mem_o_en   (mem_o_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Synchronous memory: writes land at the edge, read data appears one cycle after re_e.
  always @(posedge clk) begin
    if (mem_wr_e) mem[mem_address] <= mem_wdata;
    mem_rdata <= mem_re_e ? mem[mem_address] : 8'hEE;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r,
                               input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                               input logic dr, input logic dw, input logic [15:0] da, input logic [7:0] dd);
    @(posedge clk);
    #1;
    rst = r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  // Scoreboard: pop an expected byte whenever a port reports valid read data.
  always @(negedge clk) begin
    if (cpu_rvalid === 1'b1) begin
      if (cpuExp.size() == 0) checkOutput("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
      else checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(cpuExp.pop_front()));
    end
    if (dma_rvalid === 1'b1) begin
      if (dmaExp.size() == 0) checkOutput("dma_rvalid_unexpected", 32'(dma_rvalid), 32'd0);
      else checkOutput("dma_rdata", 32'(dma_rdata), 32'(dmaExp.pop_front()));
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));

    // Reset state
    applyStimulus(1, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    checkOutput("rst_re_e", 32'(mem_re_e), 32'd0);
    checkOutput("rst_wr_e", 32'(mem_wr_e), 32'd0);

    // Idle grant and read return
    applyStimulus(0, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("t1_gnt_latency", 32'(cpu_gnt), 32'd0);
    checkOutput("t1_no_early_re", 32'(mem_re_e), 32'd0);
    applyStimulus(0, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00);
    cpuExp.push_back(pat(16'h0010));
    @(negedge clk);
    checkOutput("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("t1_re_e", 32'(mem_re_e), 32'd1);
    checkOutput("t1_o_en", 32'(mem_o_en), 32'd1);
    checkOutput("t1_wr_e", 32'(mem_wr_e), 32'd0);
    checkOutput("t1_addr", 32'(mem_address), 32'h0010);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    checkOutput("t1_idle_re_e", 32'(mem_re_e), 32'd0);
    checkOutput("t1_idle_addr", 32'(mem_address), 32'h0000);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("t1_release_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("t1_rvalid_low", 32'(cpu_rvalid), 32'd0);
    checkOutput("t1_rdata_zero", 32'(cpu_rdata), 32'd0);

    // Tie after reset goes to CPU, next tie goes to DMA
    applyStimulus(1, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    applyStimulus(0, 1, 0, 16'h0020, 8'h00, 1, 0, 16'h0030, 8'h00);
    @(negedge clk);
    checkOutput("t2_idle_re_e", 32'(mem_re_e), 32'd0);
    applyStimulus(0, 1, 0, 16'h0020, 8'h00, 1, 0, 16'h0030, 8'h00);
    cpuExp.push_back(pat(16'h0020));
    @(negedge clk);
    checkOutput("t2_tie_cpu_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("t2_tie_dma_gnt", 32'(dma_gnt), 32'd0);
    checkOutput("t2_tie_addr", 32'(mem_address), 32'h0020);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("t2_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    applyStimulus(0, 1, 0, 16'h0020, 8'h00, 1, 0, 16'h0030, 8'h00);
    @(negedge clk);
    checkOutput("t2_idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("t2_idle_dma_gnt", 32'(dma_gnt), 32'd0);
    applyStimulus(0, 1, 0, 16'h0020, 8'h00, 1, 0, 16'h0030, 8'h00);
    dmaExp.push_back(pat(16'h0030));
    @(negedge clk);
    checkOutput("t2_rr_dma_gnt", 32'(dma_gnt), 32'd1);
    checkOutput("t2_rr_cpu_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("t2_rr_addr", 32'(mem_address), 32'h0030);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("t2_dma_rvalid", 32'(dma_rvalid), 32'd1);
    checkOutput("t2_cpu_rvalid_low", 32'(cpu_rvalid), 32'd0);

    // Hold limit: four CPU reads while DMA waits, then zero-bubble handover
    applyStimulus(0, 1, 0, 16'h0040, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("t3_pre_gnt", 32'(cpu_gnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 16'h0040 + 16'(i), 8'h00, 1, 1, 16'h1234, 8'hA5);
      cpuExp.push_back(pat(16'h0040 + 16'(i)));
      @(negedge clk);
      checkOutput($sformatf("t3_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'd1);
      checkOutput($sformatf("t3_dma_wait_%0d", i), 32'(dma_gnt), 32'd0);
      checkOutput($sformatf("t3_addr_%0d", i), 32'(mem_address), 32'h0040 + 32'(i));
      checkOutput($sformatf("t3_re_e_%0d", i), 32'(mem_re_e), 32'd1);
    end
    applyStimulus(0, 1, 0, 16'h0044, 8'h00, 1, 1, 16'h1234, 8'hA5);
    @(negedge clk);
    checkOutput("t3_dma_gnt", 32'(dma_gnt), 32'd1);
    checkOutput("t3_cpu_gnt_off", 32'(cpu_gnt), 32'd0);
    checkOutput("t3_wr_e", 32'(mem_wr_e), 32'd1);
    checkOutput("t3_wr_re_e", 32'(mem_re_e), 32'd0);
    checkOutput("t3_wr_o_en", 32'(mem_o_en), 32'd0);
    checkOutput("t3_wdata", 32'(mem_wdata), 32'h00A5);
    checkOutput("t3_wr_addr", 32'(mem_address), 32'h1234);
    checkOutput("t4_cpu_rvalid_handover", 32'(cpu_rvalid), 32'd1);
    checkOutput("t4_dma_rvalid_handover", 32'(dma_rvalid), 32'd0);

    // Non-owner isolation: CPU flips to a write elsewhere while DMA reads back
    applyStimulus(0, 1, 1, 16'hBEEF, 8'h11, 1, 0, 16'h1234, 8'h00);
    dmaExp.push_back(8'hA5);
    @(negedge clk);
    checkOutput("t6_addr", 32'(mem_address), 32'h1234);
    checkOutput("t6_wr_e", 32'(mem_wr_e), 32'd0);
    checkOutput("t6_re_e", 32'(mem_re_e), 32'd1);
    checkOutput("t6_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

    // Reset mid-burst with a DMA read requested
    applyStimulus(1, 1, 0, 16'h0050, 8'h00, 1, 0, 16'h1235, 8'h00);
    @(negedge clk);
    checkOutput("t5_rst_cycle_re_e", 32'(mem_re_e), 32'd0);
    checkOutput("t5_rst_cycle_wr_e", 32'(mem_wr_e), 32'd0);
    applyStimulus(0, 1, 0, 16'h0050, 8'h00, 1, 0, 16'h1235, 8'h00);
    @(negedge clk);
    checkOutput("t5_cpu_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("t5_dma_gnt", 32'(dma_gnt), 32'd0);
    checkOutput("t5_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("t5_dma_rvalid", 32'(dma_rvalid), 32'd0);
    checkOutput("t5_re_e", 32'(mem_re_e), 32'd0);
    applyStimulus(0, 1, 0, 16'h0050, 8'h00, 1, 0, 16'h1235, 8'h00);
    cpuExp.push_back(pat(16'h0050));
    @(negedge clk);
    checkOutput("t5_tie_cpu_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("t5_tie_dma_gnt", 32'(dma_gnt), 32'd0);
    checkOutput("t5_tie_addr", 32'(mem_address), 32'h0050);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("t5_cpu_rvalid_after", 32'(cpu_rvalid), 32'd1);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("cpu_queue_drained", 32'(cpuExp.size()), 32'd0);
    checkOutput("dma_queue_drained", 32'(dmaExp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
